// File: rtl/mem_reader.sv
// Streams a block of memory words out as bytes, most-significant byte first,
// over a valid/ready byte interface driven from a synchronous-read memory.
module mem_reader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    FIN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  done_q;
  logic                  last_byte;

  assign last_byte = (idx_q == IDXW'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      done_q      <= (state_q == FIN);
    end
  end

  // The memory read is registered, so FETCH only waits for the data that LOAD captures.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = num_words;
          state_d     = (num_words != '0) ? FETCH : FIN;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = mem_rd_data;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (last_byte) begin
            remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
            if (remaining_q > (ADDR_WIDTH+1)'(1)) begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = FETCH;
            end else begin
              state_d = FIN;
            end
          end else begin
            shift_d = shift_q << 8;
            idx_d   = idx_q + IDXW'(1);
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;
  assign tx_data  = shift_q[DATA_WIDTH-1 -: 8];
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: a transaction-level model predicts the byte
// stream, valid/busy/done timing, and is cross-checked against literal scenarios.
module tb_mem_reader;

   localparam int AW = 15;
   localparam int DW = 16;
   localparam int NB = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   num_words;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd_data;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;
   logic          busy;
   logic          done;

   int vecCount  = 0;
   int missCount = 0;
   int readyMode = 0;
   int doneSeen  = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [7:0]    txLog [$];

   // Model state: what the reader should be doing, in transaction terms
   int            cyc = 0;
   bit            active = 1'b0;
   int            acceptCyc = 0;
   int            validAt = 0;
   int            doneAt = -1;
   int            wordsLeft = 0;
   int            curLeft = 0;
   logic [AW-1:0] mAddr = '0;
   logic [DW-1:0] curWord = '0;

   mem_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .num_words  (num_words),
      .mem_addr   (mem_addr),
      .mem_rd_data(mem_rd_data),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read sample memory seen by the reader
   always @(posedge clk) mem_rd_data <= mem[mem_addr];

   // Downstream ready pattern, changed just after each rising edge
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(1, 0));
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge
   always @(negedge clk) begin
      logic          expValid;
      logic [DW-1:0] sh;
      cyc++;
      if (!rst_n) begin
         active  = 1'b0;
         doneAt  = -1;
         curLeft = 0;
      end else begin
         expValid = active && (curLeft > 0) && (cyc >= validAt);
         checkOutput("tx_valid", 32'(tx_valid), 32'(expValid));
         checkOutput("busy", 32'(busy),
                     32'(active && (cyc > acceptCyc) && (doneAt < 0 || cyc < doneAt)));
         checkOutput("done", 32'(done), 32'(cyc == doneAt));
         if (done) doneSeen++;
         if (tx_valid && tx_ready) txLog.push_back(tx_data);
         if (expValid) begin
            sh = curWord >> (8 * (curLeft - 1));
            checkOutput("tx_data", 32'(tx_data), 32'(sh[7:0]));
            if (tx_ready) begin
               curLeft--;
               if (curLeft == 0) begin
                  wordsLeft--;
                  if (wordsLeft > 0) begin
                     mAddr   = mAddr + 1'b1;
                     curWord = mem[mAddr];
                     curLeft = NB;
                     validAt = cyc + 3;
                  end else begin
                     doneAt = cyc + 2;
                  end
               end
            end
         end
         if (active && cyc == doneAt) active = 1'b0;
         if (start && !active) begin
            active    = 1'b1;
            acceptCyc = cyc;
            wordsLeft = int'(num_words);
            mAddr     = start_addr;
            if (num_words == '0) begin
               curLeft = 0;
               doneAt  = cyc + 2;
            end else begin
               curWord = mem[start_addr];
               curLeft = NB;
               validAt = cyc + 3;
               doneAt  = -1;
            end
         end
      end
   end

   // Pulse start for one cycle, then scramble the operands to prove they were latched
   task automatic applyStimulus(input logic [AW-1:0] addr, input int n);
      txLog.delete();
      @(posedge clk);
      #1;
      start      = 1'b1;
      start_addr = addr;
      num_words  = (AW+1)'(n);
      @(posedge clk);
      #1;
      start      = 1'b0;
      start_addr = AW'($urandom);
      num_words  = (AW+1)'($urandom_range(5, 0));
   endtask

   task automatic waitIdle(input int budget, input bit spur);
      bit finished = 1'b0;
      for (int i = 0; i < budget && !finished; i++) begin
         @(posedge clk);
         #1;
         if (!active) begin
            finished = 1'b1;
            start    = 1'b0;
         end else begin
            start      = spur && ($urandom_range(5, 0) == 0);
            start_addr = AW'($urandom);
            num_words  = (AW+1)'($urandom_range(5, 0));
         end
      end
      start = 1'b0;
      if (!finished) checkOutput("idle_timeout", 32'(active), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic checkLog(input string name, input int n, input logic [31:0] exp);
      logic [31:0] packed_bytes = '0;
      checkOutput({name, "_count"}, 32'(txLog.size()), 32'(n));
      foreach (txLog[i]) packed_bytes = {packed_bytes[23:0], txLog[i]};
      checkOutput(name, packed_bytes, exp);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({name, "_tx_data"}, 32'(tx_data), 32'd0);
      checkOutput({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      int d0;
      rst_n      = 1'b0;
      start      = 1'b0;
      start_addr = '0;
      num_words  = '0;
      tx_ready   = 1'b1;
      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      #1;
      checkResetOutputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Two words, always ready
      mem[16'h0010] = 16'hA1B2;
      mem[16'h0011] = 16'hC3D4;
      readyMode = 0;
      d0 = doneSeen;
      applyStimulus(15'h0010, 2);
      waitIdle(200, 1'b0);
      checkLog("bytes_ready", 4, 32'hA1B2C3D4);
      checkOutput("done_pulses_ready", 32'(doneSeen - d0), 32'd1);
      checkOutput("busy_after", 32'(busy), 32'd0);

      // Same readout with ready toggling every cycle
      readyMode = 1;
      applyStimulus(15'h0010, 2);
      waitIdle(200, 1'b0);
      checkLog("bytes_toggle", 4, 32'hA1B2C3D4);

      // Address wrap at the top of memory
      readyMode = 0;
      mem[15'h7FFF] = 16'h1234;
      mem[15'h0000] = 16'h5678;
      applyStimulus(15'h7FFF, 2);
      waitIdle(200, 1'b0);
      checkLog("bytes_wrap", 4, 32'h12345678);
      checkOutput("wrap_addr", 32'(mem_addr), 32'h0000);

      // Zero-length readout: only a done pulse
      d0 = doneSeen;
      applyStimulus(15'h0123, 0);
      waitIdle(50, 1'b0);
      checkOutput("zero_bytes", 32'(txLog.size()), 32'd0);
      checkOutput("zero_done", 32'(doneSeen - d0), 32'd1);

      // Stray start while sending a 4-word readout
      d0 = doneSeen;
      applyStimulus(15'h0200, 4);
      for (int i = 0; i < 100 && txLog.size() < 2; i++) @(posedge clk);
      #1;
      start      = 1'b1;
      start_addr = 15'h0300;
      num_words  = 16'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitIdle(300, 1'b0);
      checkOutput("stray_bytes", 32'(txLog.size()), 32'd8);
      checkOutput("stray_done", 32'(doneSeen - d0), 32'd1);

      // Reset after the third byte of a 3-word readout, then a fresh 1-word readout
      d0 = doneSeen;
      applyStimulus(15'h0400, 3);
      for (int i = 0; i < 100 && txLog.size() < 3; i++) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      checkOutput("midreset_done", 32'(doneSeen - d0), 32'd0);
      mem[15'h0100] = 16'hBEEF;
      applyStimulus(15'h0100, 1);
      waitIdle(100, 1'b0);
      checkLog("after_reset", 2, 32'h0000BEEF);

      // Randomized readouts with random back-pressure and stray starts
      for (int t = 0; t < 40; t++) begin
         readyMode = $urandom_range(2, 0);
         applyStimulus(AW'($urandom), $urandom_range(5, 0));
         waitIdle(1000, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
